uart_rx_fifo: RTL and testbench
===============================

// Module: uart_rx_fifo
// PURPOSE
//  Receiving end of the team's 8N1 UART link. Samples i_RX_Serial at mid-bit, frames bytes and checks the stop bit.
//  Buffers good bytes in a first-word-fall-through FIFO so host logic can drain bursts at its own pace.
//  Sits between the off-chip/loopback UART line and the command decoder; companion to UART_TX.
// PARAMETERS
//  CLKS_PER_BIT  217  i_Clk cycles per UART bit (25 MHz / 115200); must be >= 8
//  FIFO_ADDR_W   3    FIFO depth = 2**FIFO_ADDR_W entries (8)
// PORTS
//  i_Clk        in   1              system clock, all logic on rising edge
//  i_Rst        in   1              asynchronous, active-high reset
//  i_RX_Serial  in   1              asynchronous UART line, idle high
//  i_RD_En      in   1              pop head of FIFO this cycle (ignored when o_Empty)
//  o_RD_Data    out  8              FIFO head byte, valid while !o_Empty
//  o_Empty      out  1              FIFO holds 0 bytes
//  o_Full       out  1              FIFO holds 2**FIFO_ADDR_W bytes
//  o_Count      out  FIFO_ADDR_W+1  bytes currently held
//  o_Frame_Err  out  1              sticky: stop bit sampled low
//  o_Overflow   out  1              sticky: good byte dropped because FIFO full
//  i_Clr_Err    in   1              clears o_Frame_Err and o_Overflow next edge
// BEHAVIOUR
//  Reset: FSM=IDLE, sync flops=1, counters/pointers=0, o_Empty=1, o_Full=0, o_Count=0, o_RD_Data=0, sticky flags=0.
//  Input: 2-flop synchronizer (reset to 1); all decoding uses the synchronized line (2-cycle latency).
//  Bit counter counts 0..CLKS_PER_BIT-1; cleared on every state change.
//  FSM:
//   IDLE  : line low -> START.
//   START : at count==(CLKS_PER_BIT-1)/2, line low -> DATA, line high -> IDLE (glitch, no flag).
//   DATA  : every CLKS_PER_BIT cycles sample one bit into shift reg, LSB first; after bit 7 -> STOP.
//   STOP  : after CLKS_PER_BIT cycles sample; high -> push byte, IDLE; low -> set o_Frame_Err, discard byte, BREAK.
//   BREAK : wait for line high -> IDLE (break/stuck-low line never produces bytes).
//  Push happens on the same edge the stop bit is sampled; o_Empty falls / o_Count increments after that edge.
//  FIFO: FWFT; o_RD_Data = mem[rd_ptr]; pointers FIFO_ADDR_W+1 bits, wrap naturally.
//   Pop when o_Empty: ignored, no state change.
//   Push when o_Full with no pop: byte dropped, o_Overflow set, FIFO unchanged.
//   Push and pop same cycle: both performed, o_Count unchanged (including when full).
//  Sticky flags: set has priority over i_Clr_Err in the same cycle.
//  Reset mid-frame: frame abandoned, FIFO emptied; next valid start edge decoded normally.
//  Back-to-back frames (stop bit followed immediately by start bit) must be received without loss.
// TESTING (CLKS_PER_BIT=217, 40 ns clock, bit period 8680 ns)
//  1 Send 0x3F 8N1 -> ~9.5 bit times after start edge o_Empty=0, o_RD_Data=0x3F, o_Count=1; pulse i_RD_En -> o_Empty=1.
//  2 Send 0x00..0x07 back-to-back, no reads -> o_Full=1, o_Count=8; then send 0xAA -> o_Overflow=1; 8 reads return 0x00..0x07.
//  3 Full FIFO; i_RD_En held during the stop-bit push of 0x5A -> o_Count stays 8; last read returns 0x5A.
//  4 Drive line low for 50 clocks then high -> no byte, o_Frame_Err=0, FSM back in IDLE.
//  5 Send 0x55 with stop bit low; hold line low 3 bit times -> o_Frame_Err=1, FIFO empty; then 0xA5 received correctly.
//  6 Assert i_Rst during data bit 4 of 0xC3 -> all outputs at reset values; next frame 0xC3 -> o_RD_Data=0xC3, o_Count=1.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver with mid-bit sampling feeding a first-word-fall-through byte FIFO
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 217,
    parameter int FIFO_ADDR_W  = 3
) (
    input  logic                   i_Clk,
    input  logic                   i_Rst,
    input  logic                   i_RX_Serial,
    input  logic                   i_RD_En,
    output logic [7:0]             o_RD_Data,
    output logic                   o_Empty,
    output logic                   o_Full,
    output logic [FIFO_ADDR_W:0]   o_Count,
    output logic                   o_Frame_Err,
    output logic                   o_Overflow,
    input  logic                   i_Clr_Err
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int PTR_W = FIFO_ADDR_W + 1;
    localparam logic [CNT_W-1:0] HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    state_t             state;
    logic               rx_meta, rx_sync;
    logic [CNT_W-1:0]   clk_cnt;
    logic [2:0]         bit_idx;
    logic [7:0]         rx_byte;
    logic [7:0]         mem [2**FIFO_ADDR_W];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic               stop_tick, push, do_push, do_pop;

    assign stop_tick = (state == STOP) && (clk_cnt == LAST);
    assign push      = stop_tick & rx_sync;
    assign o_Count   = wr_ptr - rd_ptr;
    assign o_Empty   = (o_Count == '0);
    assign o_Full    = o_Count[FIFO_ADDR_W];
    assign do_pop    = i_RD_En & ~o_Empty;
    assign do_push   = push & (~o_Full | do_pop);
    assign o_RD_Data = o_Empty ? 8'h00 : mem[rd_ptr[FIFO_ADDR_W-1:0]];

    // Two-flop synchronizer; idles high so reset never looks like a start bit
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= i_RX_Serial;
            rx_sync <= rx_meta;
        end
    end

    // Frame decoder: start is re-checked at half a bit, then each bit is sampled a full period later
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state   <= IDLE;
            clk_cnt <= '0;
            bit_idx <= '0;
            rx_byte <= '0;
        end else begin
            case (state)
                IDLE: begin
                    clk_cnt <= '0;
                    if (!rx_sync) state <= START;
                end
                START: begin
                    if (clk_cnt == HALF) begin
                        clk_cnt <= '0;
                        bit_idx <= '0;
                        state   <= rx_sync ? IDLE : DATA;
                    end else clk_cnt <= clk_cnt + CNT_W'(1);
                end
                DATA: begin
                    if (clk_cnt == LAST) begin
                        clk_cnt <= '0;
                        rx_byte <= {rx_sync, rx_byte[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) state <= STOP;
                    end else clk_cnt <= clk_cnt + CNT_W'(1);
                end
                STOP: begin
                    if (clk_cnt == LAST) begin
                        clk_cnt <= '0;
                        state   <= rx_sync ? IDLE : BREAK;
                    end else clk_cnt <= clk_cnt + CNT_W'(1);
                end
                BREAK: begin
                    clk_cnt <= '0;
                    if (rx_sync) state <= IDLE;
                end
                default: begin
                    clk_cnt <= '0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    // FIFO storage needs no reset: the head is masked to zero while empty
    always_ff @(posedge i_Clk) begin
        if (do_push) mem[wr_ptr[FIFO_ADDR_W-1:0]] <= rx_byte;
    end

    // Pointers carry an extra wrap bit so full and empty are distinguishable
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    // Sticky error flags; a new error wins over a clear in the same cycle
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            o_Frame_Err <= 1'b0;
            o_Overflow  <= 1'b0;
        end else begin
            o_Frame_Err <= (stop_tick & ~rx_sync) | (o_Frame_Err & ~i_Clr_Err);
            o_Overflow  <= (push & ~do_push) | (o_Overflow & ~i_Clr_Err);
        end
    end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed checks of UART framing, FIFO fill/drain, errors and reset
module tb_uart_rx_fifo;
    localparam int CPB = 217;

    logic       i_Clk = 1'b0;
    logic       i_Rst = 1'b1;
    logic       i_RX_Serial = 1'b1;
    logic       i_RD_En = 1'b0;
    logic       i_Clr_Err = 1'b0;
    logic [7:0] o_RD_Data;
    logic       o_Empty, o_Full, o_Frame_Err, o_Overflow;
    logic [3:0] o_Count;
    int         n_checks = 0;
    int         n_pass = 0;

    uart_rx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_ADDR_W(3)) dut (
        .i_Clk(i_Clk), .i_Rst(i_Rst), .i_RX_Serial(i_RX_Serial), .i_RD_En(i_RD_En),
        .o_RD_Data(o_RD_Data), .o_Empty(o_Empty), .o_Full(o_Full), .o_Count(o_Count),
        .o_Frame_Err(o_Frame_Err), .o_Overflow(o_Overflow), .i_Clr_Err(i_Clr_Err)
    );

    always #20 i_Clk = ~i_Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge i_Clk);
    endtask

    task automatic send_bits(input logic [7:0] b);
        i_RX_Serial = 1'b0;
        wait_clks(CPB);
        for (int i = 0; i < 8; i++) begin
            i_RX_Serial = b[i];
            wait_clks(CPB);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        send_bits(b);
        i_RX_Serial = stop;
        wait_clks(CPB);
        i_RX_Serial = 1'b1;
    endtask

    task automatic pop_check(input string tag, input logic [7:0] exp);
        check(tag, o_RD_Data, exp);
        i_RD_En = 1'b1;
        wait_clks(1);
        i_RD_En = 1'b0;
    endtask

    task automatic clear_err();
        i_Clr_Err = 1'b1;
        wait_clks(1);
        i_Clr_Err = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " empty"}, o_Empty, 1);
        check({tag, " full"}, o_Full, 0);
        check({tag, " count"}, o_Count, 0);
        check({tag, " data"}, o_RD_Data, 0);
        check({tag, " ferr"}, o_Frame_Err, 0);
        check({tag, " ovf"}, o_Overflow, 0);
    endtask

    initial begin
        wait_clks(3);
        check_reset_vals("reset");
        i_Rst = 1'b0;
        wait_clks(5);

        // 1: single byte, push lands half-way through the stop bit
        send_bits(8'h3F);
        i_RX_Serial = 1'b1;
        wait_clks(100);
        check("t1 empty before stop sample", o_Empty, 1);
        wait_clks(20);
        check("t1 empty after push", o_Empty, 0);
        check("t1 data", o_RD_Data, 8'h3F);
        check("t1 count", o_Count, 1);
        wait_clks(CPB - 120);
        pop_check("t1 pop", 8'h3F);
        check("t1 empty after pop", o_Empty, 1);

        // 2: fill back-to-back, overflow, drain in order
        for (int i = 0; i < 8; i++) send_byte(8'(i), 1'b1);
        check("t2 full", o_Full, 1);
        check("t2 count", o_Count, 8);
        check("t2 no ovf yet", o_Overflow, 0);
        send_byte(8'hAA, 1'b1);
        check("t2 ovf", o_Overflow, 1);
        check("t2 count after ovf", o_Count, 8);
        for (int i = 0; i < 8; i++) pop_check("t2 drain", 8'(i));
        check("t2 empty", o_Empty, 1);
        clear_err();
        check("t2 ovf cleared", o_Overflow, 0);

        // 3: pop coinciding with push into a full FIFO
        for (int i = 0; i < 8; i++) send_byte(8'h10 + 8'(i), 1'b1);
        send_bits(8'h5A);
        i_RX_Serial = 1'b1;
        wait_clks(111);
        i_RD_En = 1'b1;
        wait_clks(1);
        i_RD_En = 1'b0;
        check("t3 count held", o_Count, 8);
        check("t3 no ovf", o_Overflow, 0);
        wait_clks(CPB - 112);
        for (int i = 1; i < 8; i++) pop_check("t3 drain", 8'h10 + 8'(i));
        pop_check("t3 last", 8'h5A);
        check("t3 empty", o_Empty, 1);

        // 4: short low glitch is rejected silently
        i_RX_Serial = 1'b0;
        wait_clks(50);
        i_RX_Serial = 1'b1;
        wait_clks(300);
        check("t4 ferr", o_Frame_Err, 0);
        check("t4 empty", o_Empty, 1);
        send_byte(8'h96, 1'b1);
        check("t4 next byte", o_RD_Data, 8'h96);
        pop_check("t4 pop", 8'h96);

        // 5: bad stop bit followed by a held break, then recovery
        send_bits(8'h55);
        i_RX_Serial = 1'b0;
        wait_clks(3 * CPB);
        i_RX_Serial = 1'b1;
        wait_clks(CPB);
        check("t5 ferr", o_Frame_Err, 1);
        check("t5 empty", o_Empty, 1);
        send_byte(8'hA5, 1'b1);
        check("t5 recover data", o_RD_Data, 8'hA5);
        check("t5 recover count", o_Count, 1);
        check("t5 ferr sticky", o_Frame_Err, 1);
        pop_check("t5 pop", 8'hA5);
        clear_err();
        check("t5 ferr cleared", o_Frame_Err, 0);

        // 6: reset during data bit 4 with a byte already queued
        send_byte(8'h11, 1'b1);
        check("t6 queued", o_Count, 1);
        i_RX_Serial = 1'b0;
        wait_clks(CPB);
        for (int i = 0; i < 4; i++) begin
            i_RX_Serial = logic'(8'hC3 >> i);
            wait_clks(CPB);
        end
        i_RX_Serial = 1'b0;
        wait_clks(100);
        i_Rst = 1'b1;
        i_RX_Serial = 1'b1;
        wait_clks(3);
        check_reset_vals("t6 in reset");
        i_Rst = 1'b0;
        wait_clks(2 * CPB);
        check_reset_vals("t6 after reset");
        send_byte(8'hC3, 1'b1);
        check("t6 data", o_RD_Data, 8'hC3);
        check("t6 count", o_Count, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
